// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, burst stepping, zero-lockup guard and wrap flag.
// Optional step counter output count_o is enabled by defining LFSR_STEP_COUNT_EN.
module lfsr_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'hC),
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               MODE  = 0,
  parameter int               LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic             lockup_o
`ifdef LFSR_STEP_COUNT_EN
  ,
  output logic [WIDTH-1:0] count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   lfsr_r;
  logic [LEN_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               wrap_r;
  logic               lockup_r;
  logic [WIDTH-1:0]   next_s;
  logic               step_en_s;

  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] s);
    if (MODE == 0) begin
      step_f = {s[WIDTH-2:0], ^(s & TAPS)};
    end else begin
      step_f = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS);
    end
  endfunction

  assign next_s = step_f(lfsr_r);

  // Load always wins; a start accepted in IDLE takes the cycle without stepping.
  always_comb begin
    step_en_s = 1'b0;
    if (load_i) begin
      step_en_s = 1'b0;
    end else if (state_r == BURST) begin
      step_en_s = 1'b1;
    end else if (state_r == IDLE) begin
      step_en_s = enable_i && !start_i;
    end else begin
      step_en_s = 1'b0;
    end
  end

`ifdef LFSR_STEP_COUNT_EN
  logic [WIDTH-1:0] count_r;

  // Step counter, restarted whenever the sequence returns to SEED.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load_i) begin
      count_r <= {WIDTH{1'b0}};
    end else if (step_en_s) begin
      count_r <= (next_s == SEED) ? {WIDTH{1'b0}} : count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;
`endif

  // State register, burst FSM and registered status flags.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_r  <= IDLE;
      lfsr_r   <= SEED;
      cnt_r    <= {LEN_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
      if (load_i) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
        cnt_r   <= {LEN_W{1'b0}};
        if (load_data_i == {WIDTH{1'b0}}) begin
          lfsr_r   <= SEED;
          lockup_r <= 1'b1;
        end else begin
          lfsr_r <= load_data_i;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (start_i) begin
              if (len_i != {LEN_W{1'b0}}) begin
                cnt_r   <= len_i;
                busy_r  <= 1'b1;
                state_r <= BURST;
              end else begin
                done_r  <= 1'b1;
                state_r <= DONE;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          BURST: begin
            cnt_r <= cnt_r - LEN_W'(1'b1);
            if (cnt_r == LEN_W'(1'b1)) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= BURST;
            end
          end
          DONE: begin
            state_r <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
        if (step_en_s) begin
          lfsr_r <= next_s;
          wrap_r <= (next_s == SEED);
        end else begin
          lfsr_r <= lfsr_r;
        end
      end
    end
  end

  assign lfsr_o   = lfsr_r;
  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign wrap_o   = wrap_r;
  assign lockup_o = lockup_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a Fibonacci instance (defaults) and a Galois instance (TAPS=3, SEED=1).
// Driver pushes hand-computed expectations after each edge; a negedge monitor pops and compares.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       f_en, f_load, f_start;
  logic [3:0] f_ld;
  logic [7:0] f_len;
  logic [3:0] f_lfsr;
  logic       f_busy, f_done, f_wrap, f_lock;
  logic       g_en;
  logic [3:0] g_lfsr;
  logic       g_busy, g_done, g_wrap, g_lock;
  logic [3:0] f_cnt, g_cnt;

  lfsr_gen dut_f (
    .clk_i(clk), .n_rst_i(n_rst), .enable_i(f_en), .load_i(f_load), .load_data_i(f_ld),
    .start_i(f_start), .len_i(f_len), .lfsr_o(f_lfsr), .busy_o(f_busy), .done_o(f_done),
    .wrap_o(f_wrap), .lockup_o(f_lock)
`ifdef LFSR_STEP_COUNT_EN
    , .count_o(f_cnt)
`endif
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(1), .LEN_W(8)) dut_g (
    .clk_i(clk), .n_rst_i(n_rst), .enable_i(g_en), .load_i(1'b0), .load_data_i(4'h0),
    .start_i(1'b0), .len_i(8'h00), .lfsr_o(g_lfsr), .busy_o(g_busy), .done_o(g_done),
    .wrap_o(g_wrap), .lockup_o(g_lock)
`ifdef LFSR_STEP_COUNT_EN
    , .count_o(g_cnt)
`endif
  );

`ifndef LFSR_STEP_COUNT_EN
  assign f_cnt = 4'h0;
  assign g_cnt = 4'h0;
`endif

  typedef struct {
    logic [3:0] lfsr;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       lock;
    logic [3:0] cnt;
  } exp_t;

  exp_t fq[$];
  exp_t gq[$];
  exp_t fe, ge;
  int   checks = 0;
  int   errors = 0;
  int   fidx = 0;
  int   gidx = 0;

  task automatic check_one(input string nm, input exp_t e, input logic [3:0] l, input logic b,
                           input logic d, input logic w, input logic k, input logic [3:0] c);
    checks++;
    if ({l, b, d, w, k} !== {e.lfsr, e.busy, e.done, e.wrap, e.lock}) begin
      errors++;
      $display("FAIL %s got lfsr=%h busy=%b done=%b wrap=%b lockup=%b want lfsr=%h busy=%b done=%b wrap=%b lockup=%b",
               nm, l, b, d, w, k, e.lfsr, e.busy, e.done, e.wrap, e.lock);
    end
`ifdef LFSR_STEP_COUNT_EN
    checks++;
    if (c !== e.cnt) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", nm, c, e.cnt);
    end
`endif
  endtask

  // Monitor: one scoreboard entry per instance per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (fq.size() > 0) begin
      fe = fq.pop_front();
      check_one($sformatf("fib[%0d]", fidx), fe, f_lfsr, f_busy, f_done, f_wrap, f_lock, f_cnt);
      fidx++;
    end
    if (gq.size() > 0) begin
      ge = gq.pop_front();
      check_one($sformatf("gal[%0d]", gidx), ge, g_lfsr, g_busy, g_done, g_wrap, g_lock, g_cnt);
      gidx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pf(input logic [3:0] l, input logic b, input logic d, input logic w,
                    input logic k, input logic [3:0] c);
    exp_t e;
    e.lfsr = l; e.busy = b; e.done = d; e.wrap = w; e.lock = k; e.cnt = c;
    fq.push_back(e);
  endtask

  task automatic pg(input logic [3:0] l, input logic w, input logic [3:0] c);
    exp_t e;
    e.lfsr = l; e.busy = 1'b0; e.done = 1'b0; e.wrap = w; e.lock = 1'b0; e.cnt = c;
    gq.push_back(e);
  endtask

  logic [3:0] fseq [15];
  logic [3:0] gseq [15];

  initial begin
    fseq = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
    gseq = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    n_rst = 1'b0; f_en = 1'b0; f_load = 1'b0; f_start = 1'b0; f_ld = 4'h0; f_len = 8'd0; g_en = 1'b0;

    // reset state
    repeat (2) begin
      tick(); pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); pg(4'h1, 1'b0, 4'd0);
    end

    // free-run, one full period on both instances
    n_rst = 1'b1; f_en = 1'b1; g_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      pf(fseq[i], 1'b0, 1'b0, (i == 14), 1'b0, (i == 14) ? 4'd0 : 4'(i + 1));
      pg(gseq[i], (i == 14), (i == 14) ? 4'd0 : 4'(i + 1));
    end

    // Fibonacci held (enable low); Galois runs its second period
    f_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      pg(gseq[i], (i == 14), (i == 14) ? 4'd0 : 4'(i + 1));
    end
    g_en = 1'b0;

    // burst of 5 with a start pulse mid-burst
    f_start = 1'b1; f_len = 8'd5;
    tick(); pf(4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    f_start = 1'b0;
    tick(); pf(4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    f_start = 1'b1; f_len = 8'd3;
    tick(); pf(4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    f_start = 1'b0;
    tick(); pf(4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    tick(); pf(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(); pf(4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    tick(); pf(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);

    // zero-length burst
    f_start = 1'b1; f_len = 8'd0;
    tick(); pf(4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    f_start = 1'b0;
    tick(); pf(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);

    // zero load replaced by SEED
    f_load = 1'b1; f_ld = 4'h0;
    tick(); pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    f_load = 1'b0;
    tick(); pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // load then a single enabled step reaching SEED
    f_load = 1'b1; f_ld = 4'h7;
    tick(); pf(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    f_load = 1'b0; f_en = 1'b1;
    tick(); pf(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    f_en = 1'b0;
    tick(); pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // load aborts a burst of 10
    f_start = 1'b1; f_len = 8'd10;
    tick(); pf(4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    f_start = 1'b0;
    tick(); pf(4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    tick(); pf(4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    f_load = 1'b1; f_ld = 4'h9;
    tick(); pf(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    f_load = 1'b0;
    repeat (2) begin
      tick(); pf(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    end

    // reset aborts a burst of 10
    f_start = 1'b1; f_len = 8'd10;
    tick(); pf(4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    f_start = 1'b0;
    tick(); pf(4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    tick(); pf(4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    n_rst = 1'b0;
    tick(); pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    n_rst = 1'b1;
    repeat (2) begin
      tick(); pf(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (fq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", fq.size(), gq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised LFSR pseudo-random generator. Selectable Fibonacci or Galois structure, arbitrary width and tap mask.
- Adds the following on top of a plain free-running register:
  - seed load;
  - a burst-step state machine for stepping a fixed number of times;
  - zero-lockup protection;
  - a period-wrap flag.
- Used as a PRBS/stimulus source and scrambler seed generator in datapath blocks.

Parameters:
- WIDTH, 4, state width in bits; legal range 2..32.
- TAPS, 4'hC, WIDTH-bit tap mask. Fibonacci: feedback taps. Galois: XOR polynomial without the x^WIDTH term, bit 0 must be 1.
- SEED, all-ones, reset/recovery state; must be non-zero.
- MODE, 0, 0 = Fibonacci, 1 = Galois.
- LEN_W, 8, width of the burst length input.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- n_rst_i  in  1  synchronous active-low reset.
- enable_i  in  1  free-run step enable, honoured in IDLE only.
- load_i  in  1  load request, highest priority after reset.
- load_data_i  in  WIDTH  value to load.
- start_i  in  1  burst start, accepted in IDLE only.
- len_i  in  LEN_W  burst step count, sampled with start_i.
- lfsr_o  out  WIDTH  current state register.
- busy_o  out  1  high while a burst is in progress.
- done_o  out  1  one-cycle pulse at burst completion.
- wrap_o  out  1  one-cycle pulse when a step returns the state to SEED.
- lockup_o  out  1  one-cycle pulse when a zero load is replaced by SEED.

Behaviour:
- Reset (n_rst_i=0 at clock edge):
  - lfsr_o=SEED; busy_o, done_o, wrap_o, lockup_o = 0; FSM=IDLE; burst counter=0.
  - Reset mid-burst aborts the burst silently.
- A "step" is one state update:
  - Fibonacci: next = {s[WIDTH-2:0], ^(s & TAPS)}.
  - Galois: next = {s[WIDTH-2:0],1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS).
  - WIDTH=4, TAPS=4'hC, MODE=0 is the legacy 4-bit generator.
- Priority per cycle: reset > load_i > burst step / enable_i step.
- Load:
  - lfsr_o <= load_data_i next cycle; no step that cycle.
  - If load_data_i==0, lfsr_o <= SEED instead and lockup_o pulses on the next cycle.
  - Load in BURST aborts the burst: FSM->IDLE, busy_o=0, no done_o.
- FSM:
  - IDLE: step when enable_i=1.
    - start_i=1 with len_i!=0: latch len_i, FSM->BURST, busy_o=1 from next cycle.
    - start_i=1 with len_i==0: FSM->DONE, no step.
  - BURST: one step per cycle, enable_i ignored, counter decrements. The step that brings the counter 1->0 moves FSM->DONE. Exactly len_i steps occur.
  - DONE: done_o=1, busy_o=0, no step, FSM->IDLE next cycle. start_i is ignored in BURST and DONE.
- wrap_o:
  - Registered; high in the cycle where lfsr_o shows SEED as the result of a step.
  - Not raised by load or reset.
- Latency: every state change is visible on lfsr_o one cycle after the causing edge. Outputs are registers only, with no combinational paths from inputs.
- An all-zero state is unreachable: reset and load both enforce non-zero.

Optional Feature:
- Macro: LFSR_STEP_COUNT_EN.
- Defined:
  - Adds output count_o [WIDTH-1:0].
  - Increments on each step and wraps modulo 2^WIDTH.
  - Cleared to 0 by reset, by load, and by any step that produces SEED (same cycle wrap_o rises).
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Fibonacci, WIDTH=4, TAPS=4'hC, SEED=F: reset, then enable_i=1 for 15 cycles -> lfsr_o = F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F; wrap_o pulses once, with the final F.
- Galois, MODE=1, TAPS=4'h3, SEED=1: free-run -> 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1; period 15; wrap_o once per period.
- Burst (Fibonacci defaults): start_i with len_i=5 in IDLE, enable_i=0 -> busy_o high 5 cycles, lfsr_o ends at 2, done_o one pulse, then IDLE. Pulsing start_i mid-burst has no effect.
- Edge cases:
  - start_i with len_i=0 -> done_o pulses the following cycle, lfsr_o unchanged, busy_o never set.
  - load_i with load_data_i=0 -> lfsr_o=SEED, lockup_o one pulse, wrap_o stays 0.
- Load mid-burst (len_i=10, load 4'h9 on 3rd burst cycle) -> lfsr_o=9, busy_o=0, no done_o. Separately, reset mid-burst -> lfsr_o=F, all flags 0.
- With LFSR_STEP_COUNT_EN: free-run from SEED -> count_o reaches 14 then returns to 0 in the wrap cycle; load clears count_o to 0.
